// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants.
//   NUM_REGS       : number of architectural GPRs
//   REG_ADDR_W     : register address width
//   ZERO_REG       : address of the hardwired-zero register
//   DEFAULT_DATA_W : default register width
package mips_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/onehot_check.sv
// Combinational legality check of the per-register write-enable vector.
// Ports:
//   vec   in  31  WriteEn[31:1]
//   any   out 1   at least one bit set
//   multi out 1   more than one bit set
//   idx   out 5   register index of the set bit (valid when any && !multi)
module onehot_check
  import mips_pkg::*;
(
  input  logic [NUM_REGS-2:0]   vec,
  output logic                  any,
  output logic                  multi,
  output logic [REG_ADDR_W-1:0] idx
);

  assign any = |vec;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - (NUM_REGS-1)'(1)));

  // vec[0] corresponds to register 1, hence the +1.
  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
      if (vec[i]) idx = REG_ADDR_W'(i + 1);
    end
  end

endmodule

// File: rtl/reg_file_onehot.sv
// 32 x DATA_W MIPS register file driven by a one-hot write-enable decoder.
// Two combinational read ports, one synchronous write port, $0 reads zero.
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       synchronous active-high reset
//   WriteEn    in  32      one-hot write enable (bit 0 ignored)
//   WriteData  in  DATA_W  write data
//   ReadReg1/2 in  5       read addresses
//   ReadData1/2 out DATA_W read data (combinational)
//   OneHotErr  out 1       sticky multi-hot write-enable flag
//   WriteCount out CNT_W   saturating committed-write count
module reg_file_onehot
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REGS-1:0]   WriteEn,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic                  OneHotErr,
  output logic [CNT_W-1:0]      WriteCount
);

  // Entry 0 has no storage; it always reads as zero.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  logic                  we_any;
  logic                  we_multi;
  logic [REG_ADDR_W-1:0] we_idx;
  logic                  commit;
  logic                  unused_we0;

  assign unused_we0 = WriteEn[0];

  onehot_check u_onehot_check (
    .vec   (WriteEn[NUM_REGS-1:1]),
    .any   (we_any),
    .multi (we_multi),
    .idx   (we_idx)
  );

  assign commit = we_any && !we_multi;

  // Storage: reset clears everything and overrides any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (we_idx == REG_ADDR_W'(i)) regs[i] <= WriteData;
      end
    end
  end

  // Sticky error flag and saturating write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      OneHotErr  <= 1'b0;
      WriteCount <= '0;
    end else begin
      if (we_multi) OneHotErr <= 1'b1;
      if (commit && (WriteCount != {CNT_W{1'b1}})) WriteCount <= WriteCount + CNT_W'(1);
    end
  end

  // Read port 1: zero register, optional write-through, then stored value.
  always_comb begin
    ReadData1 = '0;
    if (ReadReg1 != ZERO_REG) begin
      if (BYPASS && commit && (we_idx == ReadReg1)) begin
        ReadData1 = WriteData;
      end else begin
        for (int i = 1; i < int'(NUM_REGS); i++) begin
          if (ReadReg1 == REG_ADDR_W'(i)) ReadData1 = regs[i];
        end
      end
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 != ZERO_REG) begin
      if (BYPASS && commit && (we_idx == ReadReg2)) begin
        ReadData2 = WriteData;
      end else begin
        for (int i = 1; i < int'(NUM_REGS); i++) begin
          if (ReadReg2 == REG_ADDR_W'(i)) ReadData2 = regs[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_onehot.sv
// Directed self-checking bench for reg_file_onehot.
// dut0: BYPASS=0, CNT_W=16.  dut1: BYPASS=1, CNT_W=4 (small counter to reach saturation).
module tb_reg_file_onehot;

  logic        clk;
  logic        reset;
  logic [31:0] we;
  logic [31:0] wd;
  logic [4:0]  r1, r2;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        err0, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;

  reg_file_onehot #(.DATA_W(32), .BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .WriteEn(we), .WriteData(wd),
    .ReadReg1(r1), .ReadReg2(r2), .ReadData1(rd1_0), .ReadData2(rd2_0),
    .OneHotErr(err0), .WriteCount(cnt0)
  );

  reg_file_onehot #(.DATA_W(32), .BYPASS(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .WriteEn(we), .WriteData(wd),
    .ReadReg1(r1), .ReadReg2(r2), .ReadData1(rd1_1), .ReadData2(rd2_1),
    .OneHotErr(err1), .WriteCount(cnt1)
  );

  // Period 200 exceeds the decoder settle time.
  initial clk = 1'b0;
  always #100 clk = ~clk;

  typedef struct {
    logic [31:0] we;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        err;
    int          cnt;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both DUTs' non-bypassed state against expected values.
  task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                         input logic e_err, input int e_cnt);
    int sat;
    sat = (e_cnt > 15) ? 15 : e_cnt;
    chk({tag, ".rd1_0"}, rd1_0, e1);
    chk({tag, ".rd2_0"}, rd2_0, e2);
    chk({tag, ".rd1_1"}, rd1_1, e1);
    chk({tag, ".rd2_1"}, rd2_1, e2);
    chk({tag, ".err0"}, 32'(err0), 32'(e_err));
    chk({tag, ".err1"}, 32'(err1), 32'(e_err));
    chk({tag, ".cnt0"}, 32'(cnt0), 32'(e_cnt));
    chk({tag, ".cnt1"}, 32'(cnt1), 32'(sat));
  endtask

  // Apply the current inputs at one rising edge, then idle the write port.
  task automatic tick();
    @(posedge clk);
    #1;
    we    = 32'h0;
    reset = 1'b0;
  endtask

  initial begin
    vt[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 5'd8,  5'd0,  32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vt[1] = '{32'h0000_0001, 32'hFFFF_FFFF, 5'd8,  5'd0,  32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vt[2] = '{32'h0000_0002, 32'h1111_1111, 5'd1,  5'd8,  32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 2};
    vt[3] = '{32'h0000_0004, 32'h2222_2222, 5'd2,  5'd1,  32'h2222_2222, 32'h1111_1111, 1'b0, 3};
    vt[4] = '{32'h8000_0000, 32'hCAFE_F00D, 5'd31, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4};
    vt[5] = '{32'h0000_0000, 32'h0BAD_BAD0, 5'd31, 5'd2,  32'hCAFE_F00D, 32'h2222_2222, 1'b0, 4};
    vt[6] = '{32'h0000_0006, 32'h0000_1234, 5'd1,  5'd2,  32'h1111_1111, 32'h2222_2222, 1'b1, 4};
    vt[7] = '{32'h0000_0007, 32'h0000_5555, 5'd1,  5'd2,  32'h1111_1111, 32'h2222_2222, 1'b1, 4};
    vt[8] = '{32'h0000_0010, 32'h4444_4444, 5'd4,  5'd0,  32'h4444_4444, 32'h0,         1'b1, 5};

    reset = 1'b1;
    we    = 32'h0;
    wd    = 32'h0;
    r1    = 5'd0;
    r2    = 5'd0;
    tick();

    // Every address reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      r1 = 5'(a);
      r2 = 5'(31 - a);
      #5;
      chk($sformatf("rst.a%0d", a), rd1_0, 32'h0);
      chk($sformatf("rst.b%0d", a), rd2_1, 32'h0);
    end
    chk_all("rst", 32'h0, 32'h0, 1'b0, 0);

    // Table-driven write/read vectors.
    for (int v = 0; v < 9; v++) begin
      we = vt[v].we;
      wd = vt[v].wd;
      tick();
      r1 = vt[v].r1;
      r2 = vt[v].r2;
      #5;
      chk_all($sformatf("vec%0d", v), vt[v].e1, vt[v].e2, vt[v].err, vt[v].cnt);
    end

    // Eleven more legal writes: error stays sticky, small counter saturates at 15.
    for (int k = 0; k < 11; k++) begin
      we = 32'h1 << (10 + k);
      wd = 32'h1000_0000 + 32'(k);
      tick();
    end
    r1 = 5'd10;
    r2 = 5'd20;
    #5;
    chk_all("sat", 32'h1000_0000, 32'h1000_000A, 1'b1, 16);

    // Write to r31 with both ports addressing it: bypass shows new data pre-edge.
    @(negedge clk);
    we = 32'h8000_0000;
    wd = 32'hA5A5_A5A5;
    r1 = 5'd31;
    r2 = 5'd31;
    #5;
    chk("byp0.rd1", rd1_0, 32'hCAFE_F00D);
    chk("byp0.rd2", rd2_0, 32'hCAFE_F00D);
    chk("byp1.rd1", rd1_1, 32'hA5A5_A5A5);
    chk("byp1.rd2", rd2_1, 32'hA5A5_A5A5);
    tick();
    #5;
    chk_all("post_byp", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 17);

    // Register 0 reads zero even with bypass and a pending legal write elsewhere.
    @(negedge clk);
    we = 32'h0000_0008;
    wd = 32'h3333_3333;
    r1 = 5'd0;
    r2 = 5'd3;
    #5;
    chk("zero_byp", rd1_1, 32'h0);
    chk("r3_byp", rd2_1, 32'h3333_3333);
    chk("r3_nobyp", rd2_0, 32'h0);
    we = 32'h0;

    // Reset in the same cycle as a legal write to r5: reset wins.
    @(negedge clk);
    we    = 32'h0000_0020;
    wd    = 32'h7777_7777;
    reset = 1'b1;
    tick();
    r1 = 5'd5;
    r2 = 5'd31;
    #5;
    chk_all("rst_wr", 32'h0, 32'h0, 1'b0, 0);

    // First write after reset counts from zero.
    we = 32'h0000_0020;
    wd = 32'h5A5A_0005;
    tick();
    #5;
    chk_all("after_rst", 32'h5A5A_0005, 32'h0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
